// File: rtl/block_check_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : block_check_scheduler_pkg
// Brief    : Shared types and constants for the keyword-checker scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package block_check_scheduler_pkg;

    // Line-buffer depth used when the instantiating parent does not override it.
    localparam int DEFAULT_MAX_LEN = 64;

    // Idle filler fed to the checker whenever no message char is streaming.
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CLEAR  = 3'd2,
        STREAM = 3'd3,
        SETTLE = 3'd4,
        RESP   = 3'd5
    } state_t;

    // Round-robin pick: a lone requester wins outright; on a conflict the
    // requester that was not served last time wins.
    function automatic logic pick_grant(input logic v0, input logic v1,
                                        input logic last_grant);
        if (v0 && v1) begin
            return ~last_grant;
        end
        return v1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/block_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : block_line_buf
// Brief    : Message line buffer, synchronous write / combinational read.
//            Contents are intentionally not reset.
// Revision : 1.0 - initial release
// ============================================================================
module block_line_buf
    import block_check_scheduler_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_LEN,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Store one accepted message byte per handshake.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/block_check_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : block_check_scheduler
// Brief    : Shares one begin/end keyword checker between two byte-stream
//            requesters. A whole message is buffered, the checker is cleared,
//            the message is replayed without bubbles and the sampled verdict
//            is returned over a valid/ready response channel.
// Revision : 1.0 - initial release
// ============================================================================
module block_check_scheduler
    import block_check_scheduler_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int AW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    src0_data,
    input  logic          src0_valid,
    input  logic          src0_last,
    output logic          src0_ready,
    input  logic [7:0]    src1_data,
    input  logic          src1_valid,
    input  logic          src1_last,
    output logic          src1_ready,
    output logic [7:0]    chk_in,
    output logic          chk_rst,
    input  logic          chk_result,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic          rsp_pass,
    output logic          rsp_err,
    output logic [AW:0]   rsp_len,
    output logic          busy
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_LEN);
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    state_t      state;
    state_t      state_nxt;
    logic        grant;
    logic        last_grant;
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        ovf;

    logic [7:0]  sel_data;
    logic        sel_valid;
    logic        sel_last;
    logic        load_hs;
    logic        room;
    logic        any_valid;
    logic        buf_we;
    logic [7:0]  buf_rdata;

    // Only the granted requester's byte lane matters while loading.
    assign sel_data  = grant ? src1_data  : src0_data;
    assign sel_valid = grant ? src1_valid : src0_valid;
    assign sel_last  = grant ? src1_last  : src0_last;

    // Ready is a pure function of state/grant, so valid alone marks a handshake.
    assign load_hs   = (state == LOAD) && sel_valid;
    assign room      = (wptr < LEN_MAX);
    assign any_valid = src0_valid || src1_valid;
    assign buf_we    = load_hs && room;

    assign rsp_id  = grant;
    assign rsp_len = wptr;
    assign busy    = (state != IDLE);

    block_line_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wptr[AW-1:0]),
        .wdata (sel_data),
        .raddr (rptr[AW-1:0]),
        .rdata (buf_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state outputs toward requesters and checker.
    always_comb begin
        state_nxt  = state;
        src0_ready = 1'b0;
        src1_ready = 1'b0;
        chk_in     = CHAR_SPACE;
        chk_rst    = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                src0_ready = ~grant;
                src1_ready = grant;
                if (sel_valid && sel_last) begin
                    // A cancelled final write also counts as an overflow.
                    state_nxt = (ovf || !room) ? RESP : CLEAR;
                end
            end
            CLEAR: begin
                chk_rst   = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                chk_in = buf_rdata;
                if ((rptr + LEN_ONE) == wptr) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant, buffer pointers, overflow flag and verdict registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wptr       <= '0;
            rptr       <= '0;
            ovf        <= 1'b0;
            rsp_pass   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant    <= pick_grant(src0_valid, src1_valid, last_grant);
                        wptr     <= '0;
                        ovf      <= 1'b0;
                        rsp_pass <= 1'b0;
                        rsp_err  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_hs) begin
                        if (room) begin
                            wptr <= wptr + LEN_ONE;
                        end else begin
                            ovf <= 1'b1;
                        end
                        if (sel_last && (ovf || !room)) begin
                            rsp_err  <= 1'b1;
                            rsp_pass <= 1'b0;
                        end
                    end
                end
                CLEAR: begin
                    rptr <= '0;
                end
                STREAM: begin
                    rptr <= rptr + LEN_ONE;
                end
                SETTLE: begin
                    // Checker now sees a space after the final char.
                    rsp_pass <= chk_result;
                end
                RESP: begin
                    if (rsp_ready) begin
                        last_grant <= grant;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_block_check_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_check_scheduler
// Brief    : Self-checking bench for block_check_scheduler with a behavioural
//            begin/end checker and a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_check_scheduler;

    localparam int MAX_LEN = 64;
    localparam int AW      = 6;
    localparam int BOUND   = 500;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    src0_data, src1_data;
    logic          src0_valid, src1_valid, src0_last, src1_last;
    logic          src0_ready, src1_ready;
    logic [7:0]    chk_in;
    logic          chk_rst;
    logic          chk_result;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_pass, rsp_err, busy;
    logic [AW:0]   rsp_len;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hs_edge [2];
    int rst_pulses = 0;
    int exp_pulses = 0;
    int both_rdy = 0;
    logic [7:0] trace [int];
    bit         rstmark [int];

    block_check_scheduler #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .src0_data  (src0_data),
        .src0_valid (src0_valid),
        .src0_last  (src0_last),
        .src0_ready (src0_ready),
        .src1_data  (src1_data),
        .src1_valid (src1_valid),
        .src1_last  (src1_last),
        .src1_ready (src1_ready),
        .chk_in     (chk_in),
        .chk_rst    (chk_rst),
        .chk_result (chk_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_pass   (rsp_pass),
        .rsp_err    (rsp_err),
        .rsp_len    (rsp_len),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural begin/end checker: whole space-delimited words only,
    // an unmatched "end" is a sticky error, result is combinational.
    int         m_depth = 0;
    bit         m_err = 1'b0;
    int         m_tl = 0;
    logic [39:0] m_sh = '0;

    always @(posedge clk) begin
        if (chk_rst) begin
            m_depth <= 0; m_err <= 1'b0; m_tl <= 0; m_sh <= '0;
        end else if (chk_in != 8'h20) begin
            m_sh <= {m_sh[31:0], chk_in};
            m_tl <= (m_tl < 6) ? m_tl + 1 : 6;
        end else begin
            if (m_tl == 5 && m_sh == "begin") m_depth <= m_depth + 1;
            else if (m_tl == 3 && m_sh[23:0] == "end") begin
                if (m_depth == 0) m_err <= 1'b1;
                else m_depth <= m_depth - 1;
            end
            m_tl <= 0; m_sh <= '0;
        end
    end

    always_comb begin
        chk_result = !m_err && (m_depth == 0);
        if (chk_in == 8'h20) begin
            if (m_tl == 5 && m_sh == "begin") chk_result = 1'b0;
            else if (m_tl == 3 && m_sh[23:0] == "end") chk_result = !m_err && (m_depth == 1);
        end
    end

    // Trace of what the checker sees, sampled mid-cycle.
    always @(negedge clk) begin
        trace[cyc] = chk_in;
        if (chk_rst) begin
            rstmark[cyc] = 1'b1;
            rst_pulses++;
        end
        if (src0_ready && src1_ready) both_rdy++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_timeout(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // Word-level reference: pass iff every "end" closes an open "begin" and
    // nothing is left open.
    function automatic bit ref_pass(input string m);
        int d = 0;
        bit bad = 1'b0;
        int s = 0;
        for (int i = 0; i <= m.len(); i++) begin
            if (i == m.len() || m[i] == " ") begin
                string w;
                w = m.substr(s, i - 1);
                if (w == "begin") d++;
                else if (w == "end") begin
                    if (d == 0) bad = 1'b1;
                    else d--;
                end
                s = i + 1;
            end
        end
        return !bad && (d == 0);
    endfunction

    function automatic string rand_msg();
        string s = "";
        int n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) begin
            if (i > 0) s = {s, " "};
            case ($urandom_range(5))
                0, 4:    s = {s, "begin"};
                1, 5:    s = {s, "end"};
                2:       s = {s, "beginx"};
                3:       s = {s, "x"};
                default: s = {s, "en"};
            endcase
        end
        return s;
    endfunction

    function automatic string letters(input int n);
        string s = "";
        for (int i = 0; i < n; i++) begin
            s = {s, "a"};
            s.putc(i, 8'($urandom_range(97, 122)));
        end
        return s;
    endfunction

    task automatic drive(input int src, input logic v, input logic [7:0] d, input logic l);
        if (src == 0) begin src0_valid = v; src0_data = d; src0_last = l; end
        else          begin src1_valid = v; src1_data = d; src1_last = l; end
    endtask

    task automatic send(input int src, input string m, input int gap_pct);
        int waitc;
        for (int i = 0; i < m.len(); i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                @(negedge clk);
                drive(src, 1'b0, 8'h00, 1'b0);
            end
            waitc = 0;
            forever begin
                @(negedge clk);
                drive(src, 1'b1, m[i], i == m.len() - 1);
                if ((src == 0) ? src0_ready : src1_ready) break;
                waitc++;
                if (waitc > BOUND) begin
                    fail_timeout("src ready wait");
                    drive(src, 1'b0, 8'h00, 1'b0);
                    return;
                end
            end
            if (i == m.len() - 1) hs_edge[src] = cyc + 1;
        end
        @(negedge clk);
        drive(src, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic verify_stream(input int src, input string m);
        int hs = hs_edge[src];
        int nbad = 0;
        check("clear pulse after last byte", 32'(rstmark.exists(hs)), 1);
        for (int i = 0; i < m.len(); i++)
            if (!trace.exists(hs + 1 + i) || trace[hs + 1 + i] !== m[i]) nbad++;
        check("stream bytes mismatched", nbad, 0);
        check("settle char", trace.exists(hs + 1 + m.len()) ? trace[hs + 1 + m.len()] : 8'hxx, 8'h20);
    endtask

    task automatic get_rsp(input int id, input string m, input int hold);
        int n = m.len();
        bit exp_err = (n > MAX_LEN);
        int exp_len = exp_err ? MAX_LEN : n;
        bit exp_pass = exp_err ? 1'b0 : ref_pass(m);
        logic [31:0] exp_f = {22'b0, 1'(id), exp_pass, exp_err, 7'(exp_len)};
        int w = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid) break;
            w++;
            if (w > BOUND) begin
                fail_timeout("rsp_valid wait");
                return;
            end
        end
        check("rsp latency", cyc - hs_edge[id], exp_err ? 1 : n + 2);
        check("rsp fields id/pass/err/len", {22'b0, rsp_id, rsp_pass, rsp_err, rsp_len}, exp_f);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("rsp_valid held", rsp_valid, 1);
            check("rsp fields held", {22'b0, rsp_id, rsp_pass, rsp_err, rsp_len}, exp_f);
            check("src ready during resp", {src0_ready, src1_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (!exp_err) begin
            exp_pulses++;
            verify_stream(id, m);
        end else begin
            check("no clear on overflow",
                  32'(rstmark.exists(hs_edge[id]) || rstmark.exists(hs_edge[id] + 1)), 0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, {9'b0, src0_ready, src1_ready, chk_rst, rsp_valid, rsp_id, rsp_pass,
                    rsp_err, busy, rsp_len, chk_in}, 32'h20);
    endtask

    // Called at a negedge: asserts reset between edges and checks the
    // outputs before any clock edge can occur.
    task automatic do_reset(input string tag);
        #2 reset = 1'b0;
        #1 check_reset_vals(tag);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        string s60, s64, s65, s70, mlong, m, mbe;
        reset = 1'b1;
        rsp_ready = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        hs_edge[0] = 0;
        hs_edge[1] = 0;
        mbe = "begin end";

        do_reset("power-on reset outputs");

        // Basic verdicts from each requester.
        send(0, mbe, 0);                get_rsp(0, mbe, 0);
        send(1, "end begin", 0);        get_rsp(1, "end begin", 0);
        send(1, "begin beginx end", 0); get_rsp(1, "begin beginx end", 0);

        // Buffer-size boundaries: exactly full, one over (last byte dropped), 70 bytes.
        s60 = "";
        repeat (6) s60 = {s60, "begin end "};
        s64 = {s60, "x en"};
        s65 = {s60, "x end"};
        s70 = letters(70);
        send(0, s64, 0); get_rsp(0, s64, 0);
        send(1, s65, 0); get_rsp(1, s65, 0);
        send(0, s70, 0); get_rsp(0, s70, 0);

        // Both requesters from reset, each re-presenting immediately: 0,1,0,1.
        do_reset("reset before arbitration");
        fork
            begin send(0, mbe, 0); send(0, mbe, 0); end
            begin send(1, mbe, 0); send(1, mbe, 0); end
            begin
                get_rsp(0, mbe, 0); get_rsp(1, mbe, 0);
                get_rsp(0, mbe, 0); get_rsp(1, mbe, 0);
            end
        join

        // Response back-pressure with the other requester waiting.
        send(0, "begin begin end", 0);
        fork
            send(1, mbe, 0);
            begin
                get_rsp(0, "begin begin end", 5);
                check("src1_ready in idle after rsp", src1_ready, 0);
                @(negedge clk);
                check("src1 granted after rsp", src1_ready, 1);
            end
        join
        get_rsp(1, mbe, 0);

        // Asynchronous reset while streaming drops the message.
        mlong = "begin begin end end begin end begin end xx";
        send(0, mlong, 0);
        exp_pulses++;
        repeat (5) @(negedge clk);
        check("busy mid-stream", busy, 1);
        do_reset("async reset mid-stream outputs");
        send(0, mbe, 0); get_rsp(0, mbe, 0);

        // Randomized traffic with input bubbles and response back-pressure.
        for (int k = 0; k < 24; k++) begin
            int src = $urandom_range(1);
            m = ($urandom_range(7) == 0) ? letters($urandom_range(65, 80)) : rand_msg();
            send(src, m, 30);
            get_rsp(src, m, $urandom_range(3));
        end

        check("checker clear pulse count", rst_pulses, exp_pulses);
        check("both sources ready at once", both_rdy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_check_scheduler.md
Name: block_check_scheduler

Overview:
- Shares one keyword-balance checker (the begin/end checker: 8-bit char in, active-high reset, combinational `result`) between two byte-stream requesters.
- Grants the checker one whole message at a time, round-robin.
- Buffers the granted message, clears the checker, then streams the message contiguously, one char per clock. The checker cannot stall, so input bubbles must not reach it.
- Samples the checker verdict and returns it to the requester over a valid/ready response channel.

Parameters:
- MAX_LEN, 64, line-buffer depth in bytes.
- AW, $clog2(MAX_LEN), buffer address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- src0_data  in  8  requester 0 char.
- src0_valid  in  1  requester 0 char valid.
- src0_last  in  1  marks final char of message.
- src0_ready  out  1  requester 0 char accepted when valid&ready.
- src1_data / src1_valid / src1_last / src1_ready  same as src0, requester 1.
- chk_in  out  8  char to checker `in`.
- chk_rst  out  1  active-high checker clear.
- chk_result  in  1  checker `result`.
- rsp_valid  out  1  verdict valid.
- rsp_ready  in  1  verdict consumed.
- rsp_id  out  1  requester index.
- rsp_pass  out  1  sampled chk_result; 0 when rsp_err.
- rsp_err  out  1  message exceeded MAX_LEN.
- rsp_len  out  AW+1  bytes stored, saturates at MAX_LEN.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, async) forces:
  - state=IDLE, src*_ready=0, chk_in=8'h20, chk_rst=0.
  - rsp_valid=0, rsp_id=0, rsp_pass=0, rsp_err=0, rsp_len=0, busy=0.
  - wptr=0, rptr=0, ovf=0, last_grant=1, so requester 0 wins the first conflict.
  - Buffer contents are don't-care.
- States: IDLE, LOAD, CLEAR, STREAM, SETTLE, RESP.
- IDLE:
  - If any src*_valid, grant one: if only one is valid, that one; if both, the one != last_grant.
  - Latch grant, wptr=0, ovf=0, go to LOAD.
  - No data is accepted in IDLE.
- LOAD:
  - src_ready=1 for the granted source only; the other source's ready=0.
  - On each handshake with wptr<MAX_LEN: write buf[wptr], wptr++.
  - On each handshake with wptr==MAX_LEN: discard the byte, set ovf.
  - On handshake with last=1: if ovf (including a write-cancelled last byte), go to RESP with rsp_err=1, rsp_pass=0. Otherwise go to CLEAR.
  - Minimum message length is 1 byte.
- CLEAR: chk_rst=1 for exactly one cycle, rptr=0, go to STREAM.
- STREAM:
  - chk_in=buf[rptr] each cycle, rptr++.
  - After wptr cycles, go to SETTLE. The stream is contiguous, with no bubbles.
- SETTLE:
  - chk_in=8'h20.
  - Register rsp_pass<=chk_result. This reflects the checker state after the last char.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/pass/err/len held stable until rsp_ready.
  - On rsp_ready: last_grant<=grant, go to IDLE.
  - rsp_ready while rsp_valid=0 is ignored.
- chk_in=8'h20 in every state except STREAM.
- chk_rst is 0 in every state except CLEAR.
- Latency, N-byte legal message, edge 0 = last-byte handshake:
  - CLEAR in the cycle after edge 0.
  - STREAM after edges 1..N.
  - SETTLE after edge N+1.
  - rsp_valid visible after edge N+2.
- Latency, overflow: rsp_valid visible after edge 1; no chk_rst pulse.
- Overflow rsp_len=MAX_LEN.
- Reset mid-operation: immediate return to reset values; the in-flight message is dropped. The requester must resend it.

Decomposition:
- Shared package:
  - state enum, 3-bit: IDLE=0, LOAD=1, CLEAR=2, STREAM=3, SETTLE=4, RESP=5.
  - CHAR_SPACE=8'h20.
  - default MAX_LEN.
- Sub-module block_line_buf:
  - MAX_LEN x 8 storage.
  - synchronous write (we, waddr, wdata).
  - combinational read (raddr -> rdata).
  - no reset on contents.

Test Plan:
- src0 sends "begin end" (9 bytes) -> one chk_rst pulse; chk_in = the 9 chars on consecutive cycles; rsp_valid 11 edges after last handshake; rsp_id=0, rsp_pass=1, rsp_err=0, rsp_len=9.
- src1 sends "end begin" -> rsp_id=1, rsp_pass=0, rsp_len=9.
- src1 sends "begin beginx end" -> rsp_pass=1.
- Both valid right after reset, each sending "begin end" -> src0 served first, then src1. With both re-presenting immediately, the next grant is src0. The ungranted source sees ready=0 throughout.
- src0 sends 70 chars with MAX_LEN=64 -> all 70 handshakes accepted; no chk_rst pulse; rsp_err=1, rsp_pass=0, rsp_len=64, rsp_valid one edge after last handshake.
- rsp_ready held low 5 cycles in RESP -> rsp fields stable; src1_ready stays 0 while src1_valid=1; src1 is granted in the cycle after the rsp handshake.
- reset driven low mid-STREAM -> all outputs at reset values without waiting for a clock edge; a following "begin end" message completes with rsp_pass=1.
